psi_section_buffer: RTL and testbench

Parametrised successor to the PSI filter capture buffer. It stores filter-matched transport packets in a ring of fixed-size slots and replaces the old tag-and-channel header with a configurable header word. It also adds per-slot length, a drop-new or overwrite-oldest full policy, a saturating drop counter, a programmable interrupt threshold and a valid/ready streaming read port. It sits between the PSI match engine and the host register/DMA front end, entirely in the payload clock domain.

---
 rtl/psi_section_buffer.sv | 234 +++++++++++++++++++++++
 tb/tb_psi_section_buffer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psi_section_buffer.sv
// psi_section_buffer
//   Captures filter-matched transport packets into a ring of NUM_SLOTS fixed-size
//   slots and streams committed slots out over a valid/ready port. Word 0 of
//   each slot is rewritten with a header {pad, match_tag, chan} once the filter
//   verdict arrives. Full handling is either drop-new or evict-oldest.
//
//   Ports
//     payload_clk, payload_rst_n   clock, synchronous active-low reset
//     in_valid/in_start/in_end     input packet framing (no backpressure)
//     in_data                      input packet word
//     match_valid/hit/tag          one-cycle filter verdict for the last packet
//     cfg_overwrite                0 = drop new packet when full, 1 = evict oldest
//     cfg_irq_level                irq threshold on level, 0 disables
//     clear                        synchronous flush (drop_count is kept)
//     out_valid/start/end/data     read stream, out_ready accepts
//     level                        committed slots not yet fully read
//     irq                          registered level >= cfg_irq_level
//     drop_count                   packets lost, saturating
module psi_section_buffer #(
    parameter  int DATA_WIDTH = 32,
    parameter  int SLOT_WORDS = 48,
    parameter  int NUM_SLOTS  = 8,
    parameter  int TAG_WIDTH  = 16,
    localparam int LW         = $clog2(NUM_SLOTS + 1),
    localparam int OW         = $clog2(SLOT_WORDS)
) (
    input  logic                  payload_clk,
    input  logic                  payload_rst_n,
    input  logic                  in_valid,
    input  logic                  in_start,
    input  logic                  in_end,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  match_valid,
    input  logic                  match_hit,
    input  logic [TAG_WIDTH-1:0]  match_tag,
    input  logic                  cfg_overwrite,
    input  logic [LW-1:0]         cfg_irq_level,
    input  logic                  clear,
    output logic                  out_valid,
    output logic                  out_start,
    output logic                  out_end,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [LW-1:0]         level,
    output logic                  irq,
    output logic [15:0]           drop_count
);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int AW = $clog2(NUM_SLOTS * SLOT_WORDS);
    localparam logic [OW:0]   SLOT_WORDS_C = (OW + 1)'(SLOT_WORDS);
    localparam logic [LW-1:0] FULL_LVL     = LW'(NUM_SLOTS);
    localparam logic [SW-1:0] LAST_SLOT    = SW'(NUM_SLOTS - 1);

    typedef enum logic [2:0] {W_IDLE, W_CAPTURE, W_DISCARD, W_WAIT, W_COMMIT} wstate_e;

    function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
        return (s == LAST_SLOT) ? '0 : s + 1'b1;
    endfunction

    function automatic logic [AW-1:0] slot_addr(input logic [SW-1:0] s, input logic [OW:0] off);
        return AW'(s) * AW'(SLOT_WORDS) + AW'(off);
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS*SLOT_WORDS];
    logic [OW:0]           len_q [NUM_SLOTS];

    wstate_e               ws_q, ws_d;
    logic [SW-1:0]         wr_slot_q, wr_slot_d;
    logic [SW-1:0]         rd_slot_q, rd_slot_d;
    logic [OW:0]           cnt_q, cnt_d;
    logic [15:0]           chan_q, chan_d;
    logic [OW-1:0]         rd_off_q, rd_off_d;
    logic [LW-1:0]         level_q, level_d, avail;
    logic                  irq_q;
    logic [15:0]           drop_q;
    logic                  ov_q, os_q, oe_q;
    logic                  ov_d, os_d, oe_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  we;
    logic [AW-1:0]         waddr, raddr;
    logic [DATA_WIDTH-1:0] wdata, hdr;
    logic                  full, hs, rel, rd_busy, evict, drop, commit;

    assign full    = (level_q == FULL_LVL);
    assign hs      = ov_q & out_ready;
    assign rel     = hs & oe_q;
    // Once a word of the oldest slot has been accepted it cannot be evicted.
    assign rd_busy = hs | (rd_off_q != '0);

    // Write FSM: capture, wait for verdict, commit.
    always_comb begin
        ws_d      = ws_q;
        wr_slot_d = wr_slot_q;
        cnt_d     = cnt_q;
        chan_d    = chan_q;
        we        = 1'b0;
        waddr     = slot_addr(wr_slot_q, '0);
        wdata     = in_data;
        evict     = 1'b0;
        drop      = 1'b0;
        commit    = 1'b0;
        hdr             = '0;
        hdr[15:0]       = chan_q;
        hdr[16 +: TAG_WIDTH] = match_tag;
        case (ws_q)
            W_IDLE: begin
                if (in_valid && in_start) begin
                    if (full && !(cfg_overwrite && !rd_busy)) begin
                        drop = 1'b1;
                        ws_d = in_end ? W_IDLE : W_DISCARD;
                    end else begin
                        // When full, wr_slot equals rd_slot: the oldest slot is reused.
                        evict  = full;
                        we     = 1'b1;
                        cnt_d  = (OW + 1)'(1);
                        chan_d = in_data[15:0];
                        ws_d   = in_end ? W_WAIT : W_CAPTURE;
                    end
                end
            end
            W_CAPTURE: begin
                if (in_valid) begin
                    // Words past the slot end are silently truncated.
                    if (cnt_q < SLOT_WORDS_C) begin
                        we    = 1'b1;
                        waddr = slot_addr(wr_slot_q, cnt_q);
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (in_end) ws_d = W_WAIT;
                end
            end
            W_DISCARD: begin
                if (in_valid && in_end) ws_d = W_IDLE;
            end
            W_WAIT: begin
                if (match_valid) begin
                    if (match_hit) begin
                        we    = 1'b1;
                        wdata = hdr;
                        ws_d  = W_COMMIT;
                    end else begin
                        ws_d  = W_IDLE;
                    end
                end
            end
            W_COMMIT: begin
                commit    = 1'b1;
                wr_slot_d = slot_inc(wr_slot_q);
                ws_d      = W_IDLE;
            end
            default: ws_d = W_IDLE;
        endcase
    end

    // Read side: the *_d pointers name the word presented next cycle, and the
    // RAM is read at that address so a stall simply re-reads the same word.
    // An eviction while the head word is offered but not yet accepted moves the
    // head to the next oldest slot; out_valid stays up with the new word.
    always_comb begin
        rd_slot_d = rd_slot_q;
        rd_off_d  = rd_off_q;
        avail     = level_q;
        if (rel || evict) begin
            rd_slot_d = slot_inc(rd_slot_q);
            rd_off_d  = '0;
            avail     = level_q - 1'b1;
        end else if (hs) begin
            rd_off_d  = rd_off_q + 1'b1;
        end
        level_d = commit ? avail + 1'b1 : avail;
        // A slot committed this cycle becomes readable next cycle, once its len is stored.
        ov_d  = (avail != '0);
        os_d  = ov_d && (rd_off_d == '0);
        oe_d  = ov_d && ({1'b0, rd_off_d} == len_q[rd_slot_d] - 1'b1);
        raddr = slot_addr(rd_slot_d, {1'b0, rd_off_d});
    end

    always_ff @(posedge payload_clk) begin
        if (!payload_rst_n || clear) begin
            ws_q      <= W_IDLE;
            wr_slot_q <= '0;
            rd_slot_q <= '0;
            cnt_q     <= '0;
            chan_q    <= '0;
            rd_off_q  <= '0;
            level_q   <= '0;
            irq_q     <= 1'b0;
            ov_q      <= 1'b0;
            os_q      <= 1'b0;
            oe_q      <= 1'b0;
            len_q     <= '{default: '0};
        end else begin
            ws_q      <= ws_d;
            wr_slot_q <= wr_slot_d;
            rd_slot_q <= rd_slot_d;
            cnt_q     <= cnt_d;
            chan_q    <= chan_d;
            rd_off_q  <= rd_off_d;
            level_q   <= level_d;
            irq_q     <= (cfg_irq_level != '0) && (level_q >= cfg_irq_level);
            ov_q      <= ov_d;
            os_q      <= os_d;
            oe_q      <= oe_d;
            if (commit) len_q[wr_slot_q] <= cnt_q;
        end
    end

    always_ff @(posedge payload_clk) begin
        if (!payload_rst_n) begin
            drop_q <= '0;
        end else if (!clear && (drop || evict) && (drop_q != '1)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    always_ff @(posedge payload_clk) begin
        if (!payload_rst_n) rdata_q <= '0;
        else                rdata_q <= mem_q[raddr];
    end

    always_ff @(posedge payload_clk) begin
        if (payload_rst_n && !clear && we) mem_q[waddr] <= wdata;
    end

    assign out_valid  = ov_q;
    assign out_start  = os_q;
    assign out_end    = oe_q;
    assign out_data   = rdata_q;
    assign level      = level_q;
    assign irq        = irq_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_psi_section_buffer.sv
// tb_psi_section_buffer
//   Randomized packet stimulus against a packet-level reference model: stored
//   packets are kept as a queue of expected words plus a queue of packet
//   lengths. A forked monitor pops and compares on every output handshake.
module tb_psi_section_buffer;
    localparam int DW  = 32;
    localparam int SWD = 48;
    localparam int NS  = 8;
    localparam int TW  = 16;
    localparam int LW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_start = 1'b0, in_end = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          match_valid = 1'b0, match_hit = 1'b0;
    logic [TW-1:0] match_tag = '0;
    logic          cfg_ow = 1'b0;
    logic [LW-1:0] cfg_lvl = '0;
    logic          clear = 1'b0;
    logic          out_valid, out_start, out_end, out_ready;
    logic [DW-1:0] out_data;
    logic [LW-1:0] level;
    logic          irq;
    logic [15:0]   drop_count;

    always #5 clk = ~clk;

    psi_section_buffer #(
        .DATA_WIDTH(DW), .SLOT_WORDS(SWD), .NUM_SLOTS(NS), .TAG_WIDTH(TW)
    ) dut (
        .payload_clk(clk), .payload_rst_n(rst_n),
        .in_valid(in_valid), .in_start(in_start), .in_end(in_end), .in_data(in_data),
        .match_valid(match_valid), .match_hit(match_hit), .match_tag(match_tag),
        .cfg_overwrite(cfg_ow), .cfg_irq_level(cfg_lvl), .clear(clear),
        .out_valid(out_valid), .out_start(out_start), .out_end(out_end),
        .out_data(out_data), .out_ready(out_ready),
        .level(level), .irq(irq), .drop_count(drop_count)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
        logic          e;
    } word_t;

    word_t exp_q[$];
    int    pkt_len_q[$];
    int    checks = 0, errors = 0;
    int    m_drop = 0, ov_cnt = 0, hs_words = 0;
    int    rmode = 1;   // 0 low, 1 high, 2 alternate, 3 manual, 4 random
    bit    stab_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rdy_drv();
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                2: out_ready = ~out_ready;
                4: out_ready = ($urandom_range(0, 3) != 0);
                default: ;
            endcase
        end
    endtask

    task automatic monitor();
        word_t         e;
        logic [DW-1:0] pd;
        logic          ps, pe;
        bit            stall;
        int            dummy;
        stall = 1'b0;
        pd = '0; ps = 1'b0; pe = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
            if (stab_en && stall) begin
                chk("hold_valid", 32'(out_valid), 32'(1));
                chk("hold_data", out_data, pd);
                chk("hold_flags", 32'({out_start, out_end}), 32'({ps, pe}));
            end
            stall = out_valid && !out_ready;
            pd = out_data; ps = out_start; pe = out_end;
            if (out_valid && out_ready) begin
                hs_words++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual=%h expected=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_flags", 32'({out_start, out_end}), 32'({e.s, e.e}));
                    if (e.e && pkt_len_q.size() != 0) dummy = pkt_len_q.pop_front();
                end
            end
        end
    endtask

    // Drives one packet plus its verdict and updates the model at packet level.
    task automatic send_pkt(input int len, input logic [15:0] chan, input bit hit,
                            input logic [15:0] tag, input int clear_at, input bit rdy_at_commit);
        logic [DW-1:0] w[$];
        logic [DW-1:0] r;
        word_t         e;
        bit            store;
        int            n, dummy;
        for (int i = 0; i < len; i++) begin
            r = $urandom();
            if (i == 0) r[15:0] = chan;
            w.push_back(r);
        end
        store = 1'b1;
        if (pkt_len_q.size() == NS) begin
            if (m_drop < 65535) m_drop++;
            if (cfg_ow) begin
                for (int k = 0; k < pkt_len_q[0]; k++) e = exp_q.pop_front();
                dummy = pkt_len_q.pop_front();
            end else begin
                store = 1'b0;
            end
        end
        for (int i = 0; i < len; i++) begin
            in_valid = 1'b1;
            in_start = (i == 0);
            in_end   = (i == len - 1);
            in_data  = w[i];
            clear    = (i == clear_at);
            if (i == clear_at) begin
                store = 1'b0;
                exp_q.delete();
                pkt_len_q.delete();
            end
            tick();
        end
        in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0; clear = 1'b0;
        tick();
        match_valid = 1'b1; match_hit = hit; match_tag = tag;
        tick();
        match_valid = 1'b0;
        if (rdy_at_commit) out_ready = 1'b1;
        if (store && hit) begin
            n = (len < SWD) ? len : SWD;
            for (int k = 0; k < n; k++) begin
                e.d = (k == 0) ? {tag, chan} : w[k];
                e.s = (k == 0);
                e.e = (k == n - 1);
                exp_q.push_back(e);
            end
            pkt_len_q.push_back(n);
        end
        tick();
        tick();
    endtask

    task automatic st(input string nm);
        @(negedge clk);
        chk({nm, "_level"}, 32'(level), 32'(pkt_len_q.size()));
        chk({nm, "_drops"}, 32'(drop_count), 32'(m_drop));
        chk({nm, "_irq"}, 32'(irq), 32'((cfg_lvl != 0) && (pkt_len_q.size() >= int'(cfg_lvl))));
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        rmode = 1;
        while (exp_q.size() != 0 && n < 4000) begin
            tick();
            n++;
        end
        chk({nm, "_pending"}, 32'(exp_q.size()), 32'(0));
        repeat (4) tick();
        st(nm);
        chk({nm, "_idle_valid"}, 32'(out_valid), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int n;
        out_ready = 1'b1;
        fork
            monitor();
            rdy_drv();
        join_none

        // Reset with traffic applied
        rst_n = 1'b0;
        in_valid = 1'b1; in_start = 1'b1; in_end = 1'b1; in_data = 32'hDEADBEEF;
        match_valid = 1'b1; match_hit = 1'b1; match_tag = 16'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_start", 32'(out_start), 32'(0));
        chk("rst_out_end", 32'(out_end), 32'(0));
        chk("rst_out_data", out_data, 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_irq", 32'(irq), 32'(0));
        chk("rst_drops", 32'(drop_count), 32'(0));
        in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0; match_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Single 5-word hit packet
        rmode = 0;
        tick();
        send_pkt(5, 16'h0101, 1'b1, 16'h00A5, -1, 1'b0);
        st("t1");
        drain("t1");

        // Same packet rejected by the filter
        ov_cnt = 0;
        send_pkt(5, 16'h0101, 1'b0, 16'h00A5, -1, 1'b0);
        repeat (4) tick();
        st("t2");
        chk("t2_no_valid", 32'(ov_cnt), 32'(0));

        // Drop-new policy with irq threshold 5
        rmode = 0;
        cfg_ow = 1'b0;
        cfg_lvl = 4'd5;
        tick();
        for (int p = 1; p <= 9; p++) begin
            send_pkt($urandom_range(2, 12), 16'(p), 1'b1, 16'(16'h0100 + p), -1, 1'b0);
            st("t3");
        end
        drain("t3");

        // Overwrite-oldest policy from a fresh reset
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        m_drop = 0;
        rmode = 0;
        cfg_ow = 1'b1;
        cfg_lvl = '0;
        tick();
        st("t4_rst");
        for (int p = 1; p <= 10; p++) begin
            send_pkt($urandom_range(1, 10), 16'(16'h0200 + p), 1'b1, 16'(p), -1, 1'b0);
        end
        st("t4");
        drain("t4");

        // Truncation with an alternating sink
        cfg_ow = 1'b0;
        stab_en = 1'b1;
        hs_words = 0;
        rmode = 2;
        send_pkt(60, 16'h0303, 1'b1, 16'h0033, -1, 1'b0);
        drain("t5");
        chk("t5_words", 32'(hs_words), 32'(48));
        stab_en = 1'b0;

        // Clear mid-capture discards everything stored so far
        rmode = 0;
        cfg_lvl = 4'd1;
        tick();
        send_pkt(4, 16'h0404, 1'b1, 16'h0044, -1, 1'b0);
        st("t6_pre");
        send_pkt(10, 16'h0505, 1'b1, 16'h0055, 4, 1'b0);
        repeat (2) tick();
        st("t6_clr");
        rmode = 1;
        send_pkt(6, 16'h0606, 1'b1, 16'h0066, -1, 1'b0);
        drain("t6");

        // Commit in the same cycle as the out_end handshake
        cfg_lvl = '0;
        rmode = 3;
        tick();
        out_ready = 1'b0;
        tick();
        send_pkt(1, 16'h0707, 1'b1, 16'h0077, -1, 1'b0);
        repeat (2) tick();
        send_pkt(3, 16'h0808, 1'b1, 16'h0088, -1, 1'b1);
        @(negedge clk);
        chk("t7_level_same", 32'(level), 32'(1));
        drain("t7");

        // Random traffic, random sink, kept below full
        stab_en = 1'b1;
        rmode = 4;
        for (int p = 0; p < 25; p++) begin
            n = 0;
            while (pkt_len_q.size() >= NS - 2 && n < 2000) begin
                tick();
                n++;
            end
            if (n >= 2000) begin
                checks++;
                errors++;
                $display("FAIL rnd_throttle actual=%0d expected<%0d", pkt_len_q.size(), NS - 2);
            end
            send_pkt($urandom_range(1, 60), 16'($urandom()), ($urandom_range(0, 3) != 0),
                     16'($urandom()), -1, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain("t8");
        stab_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
